dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the 24-bit data memory, which has combinational read and a write on the rising clock edge. Port 0 is the CPU load/store path and port 1 is the DMA/debug path. The block latches one request, drives the memory port for exactly one cycle, then returns read data with a one-cycle Ack pulse. Simultaneous requests are resolved round-robin.

---
 rtl/dmem_arbiter_if.sv | 14 +
 rtl/dmem_arbiter.sv | 81 ++++++++
 tb/tb_dmem_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side and memory-side signals of the two-port data-memory arbiter.
interface dmem_arbiter_if #(parameter int DATA_W = 24, parameter int ADDR_W = 24);
  logic req0, req1, we0, we1, ack0, ack1, err0, err1, busy, mem_mem_write;
  logic [ADDR_W-1:0] addr0, addr1, mem_address;
  logic [DATA_W-1:0] wdata0, wdata1, rdata0, rdata1, mem_write_data, mem_mem_data;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_mem_data,
    output ack0, ack1, err0, err1, rdata0, rdata1, busy, mem_address, mem_write_data, mem_mem_write
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_mem_data,
    input  ack0, ack1, err0, err1, rdata0, rdata1, busy, mem_address, mem_write_data, mem_mem_write
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port sequencer (IDLE -> ACCESS -> RESP) for the data memory.
// Define DMEM_ARB_BOUNDS_EN to suppress and flag accesses at addresses >= DEPTH.
module dmem_arbiter #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 24,
  parameter int DEPTH  = 24
) (
  input logic clk,
  input logic rst_n,
  dmem_arbiter_if.slave bus
);
`ifdef DMEM_ARB_BOUNDS_EN
  localparam logic BOUNDS = 1'b1;
`else
  localparam logic BOUNDS = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] LIM = ADDR_W'(DEPTH);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic last, owner, we, bad, sel, sel_bad;
  logic ack0, ack1, err0, err1;
  logic [ADDR_W-1:0] addr, sel_addr;
  logic [DATA_W-1:0] wdata, rdata0, rdata1;
  // on a tie the port that did not own the last grant wins
  always_comb begin
    sel = bus.req1 && (!bus.req0 || !last);
    sel_addr = sel ? bus.addr1 : bus.addr0;
    sel_bad = BOUNDS && (sel_addr >= LIM);
    state_nx = state == IDLE ? ((bus.req0 || bus.req1) ? ACCESS : IDLE) :
               state == ACCESS ? RESP : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last <= 1'b1;
      owner <= 1'b0;
      we <= 1'b0;
      bad <= 1'b0;
      addr <= '0;
      wdata <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.req0 || bus.req1) begin
        owner <= sel;
        we <= sel ? bus.we1 : bus.we0;
        addr <= sel_addr;
        wdata <= sel ? bus.wdata1 : bus.wdata0;
        bad <= sel_bad;
      end
    end else if (state == ACCESS) begin
      last <= owner;
      ack0 <= !owner;
      ack1 <= owner;
      err0 <= !owner && bad;
      err1 <= owner && bad;
      if (!we && !owner) rdata0 <= bad ? '0 : bus.mem_mem_data;
      if (!we && owner) rdata1 <= bad ? '0 : bus.mem_mem_data;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
    end
  assign bus.ack0 = ack0;
  assign bus.ack1 = ack1;
  assign bus.err0 = err0;
  assign bus.err1 = err1;
  assign bus.rdata0 = rdata0;
  assign bus.rdata1 = rdata1;
  assign bus.busy = state != IDLE;
  assign bus.mem_address = addr;
  assign bus.mem_write_data = wdata;
  assign bus.mem_mem_write = state == ACCESS && we && !bad;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a combinational-read memory model.
module tb_dmem_arbiter;
`ifdef DMEM_ARB_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif
  typedef struct {logic port; logic [23:0] data; logic err;} exp_t;
  exp_t q[$];
  int stamps[$];
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0, n_err = 0, cyc = 0, t0 = 0, more0 = 0, more1 = 0;
  bit re0, re1, hold1, mw_seen, prev_mw;
  logic [23:0] golden [64];
  logic [23:0] mem [64];
  logic [23:0] mrd0 = '0, mrd1 = '0;
  dmem_arbiter_if bus ();
  dmem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.mem_mem_data = mem[bus.mem_address[5:0]];
  always @(posedge clk) if (bus.mem_mem_write) mem[bus.mem_address[5:0]] <= bus.mem_write_data;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(bit p, bit w, logic [23:0] a, logic [23:0] d);
    bit bad = BOUNDS && a >= 24;
    if (w && !bad) golden[a[5:0]] = d;
    if (!w && p) mrd1 = bad ? 24'h0 : golden[a[5:0]];
    if (!w && !p) mrd0 = bad ? 24'h0 : golden[a[5:0]];
    q.push_back('{p, p ? mrd1 : mrd0, bad});
    if (p) begin bus.req1 = 1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
    else begin bus.req0 = 1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
  endtask

  task automatic run(int budget);
    exp_t e;
    int n = 0;
    while (q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.mem_mem_write) begin mw_seen = 1; chk("mw_consec", prev_mw, 0); end
      prev_mw = bus.mem_mem_write;
      if (re0) begin re0 = 0; issue(0, 0, 5, 0); end
      if (re1) begin re1 = 0; issue(1, 0, 3, 0); end
      if (bus.ack0 || bus.ack1) begin
        e = q.pop_front();
        stamps.push_back(cyc);
        chk("ack_port", {bus.ack0, bus.ack1}, e.port ? 2'b01 : 2'b10);
        chk("rdata", e.port ? bus.rdata1 : bus.rdata0, e.data);
        chk("err", e.port ? bus.err1 : bus.err0, e.err);
        if (bus.ack0) begin
          bus.req0 = 0;
          if (more0 > 0) begin more0--; re0 = 1; end
        end
        if (bus.ack1) begin
          if (hold1) hold1 = 0;
          else begin
            bus.req1 = 0;
            if (more1 > 0) begin more1--; re1 = 1; end
          end
        end
      end
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic reset_checks();
    chk("rst_ctl", {bus.busy, bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_mem_write}, 0);
    chk("rst_addr", bus.mem_address, 0);
    chk("rst_wdata", bus.mem_write_data, 0);
    chk("rst_rdata0", bus.rdata0, 0);
    chk("rst_rdata1", bus.rdata1, 0);
  endtask

  initial begin
    {bus.req0, bus.req1, bus.we0, bus.we1} = '0;
    {bus.addr0, bus.addr1, bus.wdata0, bus.wdata1} = '0;
    repeat (2) @(negedge clk);
    reset_checks();
    rst_n = 1;
    @(negedge clk);
    // port 0 write with exact cycle checks, then read back
    t0 = cyc;
    issue(0, 1, 5, 24'hABCDEF);
    @(negedge clk);
    chk("wr_mw", bus.mem_mem_write, 1);
    chk("wr_addr", bus.mem_address, 5);
    chk("wr_wdata", bus.mem_write_data, 24'hABCDEF);
    chk("wr_early_ack", {bus.ack0, bus.busy}, 2'b01);
    prev_mw = 1;
    stamps.delete();
    run(10);
    chk("wr_lat", stamps[0] - t0, 2);
    @(negedge clk);
    issue(0, 0, 5, 0);
    run(10);
    // simultaneous writes: port 0 owned last grant, so port 1 goes first
    @(negedge clk);
    issue(1, 1, 3, 24'h333333);
    issue(0, 1, 4, 24'h444444);
    run(20);
    // reset in the middle of ACCESS
    @(negedge clk);
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 7; bus.wdata0 = 24'h777777;
    @(negedge clk);
    chk("mid_mw_before", bus.mem_mem_write, 1);
    rst_n = 0;
    #1;
    chk("mid_mw_drop", {bus.mem_mem_write, bus.busy}, 0);
    bus.req0 = 0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_no_ack", {bus.ack0, bus.ack1}, 0);
    end
    reset_checks();
    mrd0 = '0; mrd1 = '0;
    rst_n = 1;
    @(negedge clk);
    // simultaneous reads after reset: port 0 first, port 1 three cycles later
    issue(0, 0, 3, 0);
    issue(1, 0, 4, 0);
    stamps.delete();
    run(20);
    chk("tie_gap", stamps[1] - stamps[0], 3);
    // sustained contention, four transactions per port
    @(negedge clk);
    more0 = 3; more1 = 3;
    issue(0, 0, 5, 0);
    issue(1, 0, 3, 0);
    stamps.delete();
    run(60);
    chk("cont_acks", stamps.size(), 8);
    chk("cont_span", stamps[7] - stamps[0], 21);
    // req1 held through its ack is a second transaction
    @(negedge clk);
    hold1 = 1;
    issue(1, 0, 4, 0);
    q.push_back(q[q.size()-1]);
    stamps.delete();
    run(20);
    chk("hold_gap", stamps[1] - stamps[0], 3);
    // address range handling
    @(negedge clk);
    mw_seen = 0;
    issue(1, 1, 24, 24'h242424);
    run(10);
    chk("oob_mw", mw_seen, !BOUNDS);
    @(negedge clk);
    issue(1, 0, BOUNDS ? 24'd30 : 24'd24, 0);
    run(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
